cbpa_pipe: RTL
==============

# cbpa_pipe

Pipelined, parametrised carry-bypass adder/subtractor for the floating-point adder datapath. It splits an N-bit operation into N/BLK ripple blocks, one block per pipeline stage, with a per-block carry-bypass multiplexer. It accepts one operation per cycle under a valid/ready handshake and stalls the whole pipeline on back-pressure. It adds a subtract mode, a per-block bypass status mask and signed-overflow reporting at any width.

## Interface
- N, default 32: operand width; must be a multiple of BLK and at least 2.
- BLK, default 8: bits per bypass block. STAGES = N/BLK is both the pipeline depth and the number of blocks.
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset, synchronous and active-high.
- in_valid, input, 1: R, T, cin and sub are valid this cycle.
- in_ready, output, 1: the block accepts an operation this cycle.
- R, input, N: operand A.
- T, input, N: operand B.
- cin, input, 1: carry-in, used only when sub=0.
- sub, input, 1: 0 computes R+T+cin; 1 computes R+~T+1, i.e. R−T.
- out_valid, output, 1: the result outputs are valid.
- out_ready, input, 1: downstream accepts the result.
- sum, output, N: result.
- cout, output, 1: carry-out of the MSB. In subtract mode, 1 means no borrow.
- OF, output, 1: two's-complement overflow.
- bypass_mask, output, STAGES: bit k is 1 when block k's carry-out was taken from its carry-in over the bypass path.

## Operation
- Effective B is Be = sub ? ~T : T. Effective carry-in is ce = sub ? 1 : cin.
- Block k covers bits [k·BLK+BLK−1 : k·BLK].
  - Propagate: p_k = &(A^Be) over the block.
  - Block carry-out = p_k ? block carry-in : ripple carry-out.
  - bypass_mask[k] = p_k.
- Stage k computes block k from:
  - the registered carry of stage k−1 (ce for stage 0);
  - the operand slice, delayed k cycles by skew registers.
- Sum slices are deskewed so all N bits of one operation leave together.
- cout is the carry-out of block STAGES−1.
- OF = (A[N−1] ~^ Be[N−1]) & (sum[N−1] ^ A[N−1]).
- sub, the masks, the carries and the valid bit travel with each operation. Operations never interleave.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - A transfer in occurs when in_valid & in_ready.
  - A transfer out occurs when out_valid & out_ready.
  - On stall, every pipeline register holds and the outputs stay stable.
  - An unstalled cycle with in_valid=0 inserts a bubble with valid bit 0.
- Results emerge in issue order with no loss and no duplication.
- Any N/BLK combination is legal provided N%BLK==0. BLK==N degenerates to one stage, i.e. a registered single-block bypass adder.

## Timing
- Latency: an operation accepted at edge e presents out_valid=1 with its result after edge e+STAGES−1. With STAGES=1 the result appears after the accepting edge itself.
- Throughput: one operation per cycle when out_ready stays high.
- in_ready is combinational from out_ready and out_valid. No other input-to-output combinational path exists.
- Reset, rst high at a rising edge:
  - out_valid, sum, cout, OF and bypass_mask become 0.
  - All in-flight valid bits clear and the operations are discarded.
  - in_ready=1 in the cycle after reset.
- Reset takes priority over stall and over a simultaneous transfer in.
- Inputs presented while in_ready=0 are ignored. The source must hold them.
- Simultaneous transfer in and transfer out is the normal steady state and needs no special handling.
- Output regs change only on an unstalled edge or on reset.

## Test plan
All scenarios use N=32, BLK=8, latency 4.
- Reset: assert rst for 2 cycles with in_valid=1 → out_valid=0, sum=0, cout=0, OF=0, bypass_mask=0; in_ready=1 after release; nothing emerges from the pre-reset inputs.
- Full propagate: R=0xFFFFFFFF, T=0, cin=1, sub=0 → after 4 cycles, sum=0x00000000, cout=1, OF=0, bypass_mask=4'b1111.
- Signed overflow: R=0x7FFFFFFF, T=1, cin=0, sub=0 → sum=0x80000000, cout=0, OF=1, bypass_mask=4'b0110.
- Subtract:
  - R=5, T=7, sub=1 → sum=0xFFFFFFFE, cout=0, OF=0, bypass_mask=4'b1110.
  - Next cycle, R=0x80000000, T=1, sub=1 → sum=0x7FFFFFFF, cout=1, OF=1.
- Back-pressure: issue 8 back-to-back random operations while out_ready toggles pseudo-randomly → exactly 8 results, in order, each matching the reference model; outputs stable during every stall; in_ready=0 exactly when out_valid=1 and out_ready=0.
- Mid-flight reset: issue 3 operations, assert rst 2 cycles after the first → no result from those 3 ever appears; a new operation R=1, T=1 issued after reset yields sum=2 exactly 4 cycles later.

Source files
------------

// File: rtl/cbpa_pipe.sv
// Pipelined carry-bypass adder/subtractor: one BLK-bit ripple block per stage,
// operands skewed in, sum/mask slices deskewed out, whole pipe stalls on back-pressure.

module cbpa_blk #(
  parameter int BLK = 8
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co,
  output logic           p
);
  logic rc;

  assign {rc, s} = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, ci};
  assign p       = &(a ^ b);
  // When every bit propagates, the block carry-out is simply its carry-in.
  assign co      = p ? ci : rc;
endmodule

module cbpa_pipe #(
  parameter int N   = 32,
  parameter int BLK = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       R,
  input  logic [N-1:0]       T,
  input  logic               cin,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       sum,
  output logic               cout,
  output logic               OF,
  output logic [N/BLK-1:0]   bypass_mask
);
  localparam int STAGES = N / BLK;
  // Triangular packing: stage k keeps (k+1) sum slices and mask bits,
  // and (STAGES-1-k) operand slices still waiting for their block.
  localparam int SW  = BLK * STAGES * (STAGES + 1) / 2;
  localparam int MW  = STAGES * (STAGES + 1) / 2;
  localparam int AW0 = BLK * STAGES * (STAGES - 1) / 2;
  localparam int AW  = (AW0 > 0) ? AW0 : 1;

  logic              en, vld_in, ce, of_q, of_d;
  logic [N-1:0]      be;
  logic [STAGES:1]   vld_pipe, vld_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [SW-1:0]     s_tri, s_tri_d;
  logic [MW-1:0]     m_tri, m_tri_d;
  logic [AW-1:0]     a_tri, a_tri_d, b_tri, b_tri_d;

  assign out_valid = vld_pipe[STAGES];
  assign in_ready  = ~(out_valid & ~out_ready);
  assign en        = in_ready;
  assign vld_in    = in_valid & in_ready;
  assign be        = sub ? ~T : T;
  assign ce        = sub | cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int RW = (STAGES - k) * BLK;
    localparam int SO = BLK * k * (k + 1) / 2;
    localparam int MO = k * (k + 1) / 2;
    localparam int AO = BLK * (k * (STAGES - 1) - k * (k - 1) / 2);
    logic [RW-1:0]  a_in, b_in;
    logic [BLK-1:0] s;
    logic           ci, co, p;

    if (k == 0) begin : g_head
      assign a_in               = R;
      assign b_in               = be;
      assign ci                 = ce;
      assign vld_d[1]           = vld_in;
      assign s_tri_d[SO +: BLK] = s;
      assign m_tri_d[MO]        = p;
    end else begin : g_body
      localparam int SOP = BLK * (k - 1) * k / 2;
      localparam int MOP = (k - 1) * k / 2;
      localparam int AOP = BLK * ((k - 1) * (STAGES - 1) - (k - 1) * (k - 2) / 2);
      assign a_in                       = a_tri[AOP +: RW];
      assign b_in                       = b_tri[AOP +: RW];
      assign ci                         = c_q[k-1];
      assign vld_d[k+1]                 = vld_pipe[k];
      assign s_tri_d[SO +: (k+1)*BLK]   = {s, s_tri[SOP +: k*BLK]};
      assign m_tri_d[MO +: k+1]         = {p, m_tri[MOP +: k]};
    end

    if (k < STAGES - 1) begin : g_fwd
      assign a_tri_d[AO +: RW-BLK] = a_in[RW-1:BLK];
      assign b_tri_d[AO +: RW-BLK] = b_in[RW-1:BLK];
    end else begin : g_tail
      // Last block holds the MSB, so overflow is resolved here.
      assign of_d = (a_in[BLK-1] ~^ b_in[BLK-1]) & (s[BLK-1] ^ a_in[BLK-1]);
    end

    assign c_d[k] = co;

    cbpa_blk #(.BLK(BLK)) u_blk (
      .a  (a_in[BLK-1:0]),
      .b  (b_in[BLK-1:0]),
      .ci (ci),
      .s  (s),
      .co (co),
      .p  (p)
    );
  end

  if (AW0 == 0) begin : g_noskew
    assign a_tri_d = '0;
    assign b_tri_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      c_q      <= '0;
      s_tri    <= '0;
      m_tri    <= '0;
      a_tri    <= '0;
      b_tri    <= '0;
      of_q     <= 1'b0;
    end else if (en) begin
      vld_pipe <= vld_d;
      c_q      <= c_d;
      s_tri    <= s_tri_d;
      m_tri    <= m_tri_d;
      a_tri    <= a_tri_d;
      b_tri    <= b_tri_d;
      of_q     <= of_d;
    end
  end

  assign sum         = s_tri[SW-N +: N];
  assign cout        = c_q[STAGES-1];
  assign OF          = of_q;
  assign bypass_mask = m_tri[MW-STAGES +: STAGES];
endmodule
